spi_slave_reg_ctrl: RTL
=======================

// Module: spi_slave_reg_ctrl
// PURPOSE
//  Sequences the byte-level SPI slave into a register-access protocol in the i_Clk domain.
//  Consumes received bytes (RX DV/byte) and decodes them as command, then data.
//  Drives generic register-bus strobes and loads the slave's TX byte for reads.
//  Sits between the SPI slave and the chip's control/status register file.
// PARAMETERS
//  ADDR_W     7      register address width; the command byte carries addr[6:0], so ADDR_W<=7
//  IDLE_BYTE  8'hA5  byte preloaded to TX while no read is active (first MISO byte of every frame)
// PORTS
//  i_Clk          in   1       system clock; all logic on its rising edge
//  i_Rst_L        in   1       reset, synchronous, active-low
//  i_SPI_CS_n     in   1       raw SPI chip select; synchronised internally (2 flops)
//  i_RX_DV        in   1       one-cycle pulse: i_RX_Byte is valid
//  i_RX_Byte      in   8       received byte
//  o_TX_DV        out  1       one-cycle pulse: load o_TX_Byte into the slave
//  o_TX_Byte      out  8       byte for the slave to shift out next
//  o_Reg_Addr     out  ADDR_W  register address
//  o_Reg_WE       out  1       one-cycle write strobe; o_Reg_WData valid with it
//  o_Reg_WData    out  8       write data
//  o_Reg_RE       out  1       one-cycle read strobe
//  i_Reg_RData    in   8       read data, valid exactly 1 cycle after o_Reg_RE
//  o_Busy         out  1       high while state != IDLE
//  o_Overrun      out  1       sticky: an RX byte arrived while a read fetch was pending
// BEHAVIOUR
//  Reset (i_Rst_L=0 at a clock edge):
//   - State goes to IDLE.
//   - All strobes and o_TX_DV are 0; o_TX_Byte=IDLE_BYTE.
//   - o_Reg_Addr, o_Reg_WData, o_Busy and o_Overrun are 0.
//  Command byte: bit7 = R/nW (1 = read); bits[ADDR_W-1:0] = start address; unused bits are ignored.
//  CS sync: cs_s is i_SPI_CS_n after two flops. A cs_s rising edge ends the frame:
//   - State goes to IDLE next cycle, from any state.
//   - One o_TX_DV pulse with IDLE_BYTE is issued.
//   - A fetch in flight completes on the bus but its data is discarded (no TX_DV).
//  States:
//   IDLE   - on i_RX_DV with cs_s=0: latch the address into o_Reg_Addr.
//            Read command -> FETCH. Write command -> WRITE.
//   WRITE  - each i_RX_DV: o_Reg_WE=1 and o_Reg_WData=i_RX_Byte in the next cycle, at the current address.
//            The address increments in the cycle after the strobe.
//   FETCH  - o_Reg_RE=1 for 1 cycle -> WAIT.
//   WAIT   - capture i_Reg_RData into o_TX_Byte and pulse o_TX_DV -> READ.
//            TX_DV comes 3 cycles after the command RX_DV.
//   READ   - each i_RX_DV (master dummy byte): increment the address -> FETCH.
//  Address arithmetic: wraps modulo 2^ADDR_W (for example 0x7F -> 0x00 when ADDR_W=7). There is no error on wrap.
//  Overrun: i_RX_DV seen in FETCH or WAIT sets o_Overrun; that byte is dropped.
//   o_Overrun is cleared only by reset.
//  Simultaneous events:
//   - cs_s rising edge together with i_RX_DV: the CS edge wins and the byte is ignored.
//   - i_RX_DV while cs_s=1 is ignored.
//  Clocking: i_Clk is at least 8x the SPI clock, so the TX reload meets the next-byte preload window.
// TESTING
//  1. Reset held 2 cycles, then released -> all outputs at reset values, o_TX_Byte=0xA5, no strobes.
//  2. Write frame: CS low, bytes 0x05, 0x11, 0x22, CS high.
//     -> WE at addr 5 with data 0x11, then WE at addr 6 with data 0x22.
//     -> Then one TX_DV carrying 0xA5.
//  3. Read frame: CS low, byte 0x83 with RData(3)=0x3C, RData(4)=0x4D.
//     -> RE at addr 3, then TX_DV with 0x3C 3 cycles after RX_DV.
//     -> A dummy byte gives RE at addr 4, then TX_DV with 0x4D.
//  4. Wrap: write command 0x7F followed by 2 data bytes -> WE at addr 0x7F, then WE at addr 0x00.
//  5. Overrun: read command, then inject RX_DV in the FETCH cycle.
//     -> o_Overrun=1 and the byte is dropped; the sequence completes normally.
//  6. Abort and reset: CS rising edge during WAIT -> IDLE, TX_DV with 0xA5, no stale data.
//     -> Then reset mid-WRITE: no further WE.

Source files
------------

// File: rtl/spi_slave_reg_ctrl_if.sv
// spi_slave_reg_ctrl_if: byte-level SPI slave handshake plus generic register bus
interface spi_slave_reg_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              i_SPI_CS_n;
    logic              i_RX_DV;
    logic [7:0]        i_RX_Byte;
    logic              o_TX_DV;
    logic [7:0]        o_TX_Byte;
    logic [ADDR_W-1:0] o_Reg_Addr;
    logic              o_Reg_WE;
    logic [7:0]        o_Reg_WData;
    logic              o_Reg_RE;
    logic [7:0]        i_Reg_RData;
    logic              o_Busy;
    logic              o_Overrun;

    modport slave (
        input  i_SPI_CS_n, i_RX_DV, i_RX_Byte, i_Reg_RData,
        output o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_WE, o_Reg_WData, o_Reg_RE, o_Busy, o_Overrun
    );

    modport master (
        output i_SPI_CS_n, i_RX_DV, i_RX_Byte, i_Reg_RData,
        input  o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_WE, o_Reg_WData, o_Reg_RE, o_Busy, o_Overrun
    );
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: turns SPI slave bytes into auto-incrementing register reads/writes
module spi_slave_reg_ctrl #(
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] IDLE_BYTE = 8'hA5
) (
    input logic                 i_Clk,
    input logic                 i_Rst_L,
    spi_slave_reg_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_FETCH, S_WAIT, S_READ} state_t;

    state_t            state_q, state_d;
    logic              cs_meta_q, cs_s_q, cs_prev_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d, tx_byte_q, tx_byte_d;
    logic              we_q, we_d, tx_dv_q, tx_dv_d, overrun_q, overrun_d;
    logic              cs_rise, rx_v;

    assign cs_rise = cs_s_q & ~cs_prev_q;
    assign rx_v    = bus.i_RX_DV & ~cs_s_q;

    // registers; CS synchroniser resets to deasserted so leaving reset never looks like an edge
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            cs_meta_q <= 1'b1;
            cs_s_q    <= 1'b1;
            cs_prev_q <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= IDLE_BYTE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_meta_q <= bus.i_SPI_CS_n;
            cs_s_q    <= cs_meta_q;
            cs_prev_q <= cs_s_q;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            overrun_q <= overrun_d;
        end
    end

    // next state: command byte picks the path, a CS rising edge aborts from anywhere
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rx_v) state_d = bus.i_RX_Byte[7] ? S_FETCH : S_WRITE;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_READ;
            S_READ:  if (rx_v) state_d = S_FETCH;
            default: state_d = state_q;
        endcase
        if (cs_rise) state_d = S_IDLE;
    end

    // datapath: address latch/increment, write strobe, TX reload and sticky overrun
    always_comb begin
        addr_d    = (state_q == S_IDLE && rx_v) ? bus.i_RX_Byte[ADDR_W-1:0]
                  : (we_q || (state_q == S_READ && rx_v)) ? addr_q + ADDR_W'(1) : addr_q;
        we_d      = state_q == S_WRITE && rx_v;
        wdata_d   = we_d ? bus.i_RX_Byte : wdata_q;
        tx_dv_d   = cs_rise || state_q == S_WAIT;
        tx_byte_d = cs_rise ? IDLE_BYTE : (state_q == S_WAIT) ? bus.i_Reg_RData : tx_byte_q;
        overrun_d = overrun_q || (rx_v && (state_q == S_FETCH || state_q == S_WAIT));
    end

    assign bus.o_Reg_RE    = state_q == S_FETCH;
    assign bus.o_Busy      = state_q != S_IDLE;
    assign bus.o_Reg_Addr  = addr_q;
    assign bus.o_Reg_WE    = we_q;
    assign bus.o_Reg_WData = wdata_q;
    assign bus.o_TX_DV     = tx_dv_q;
    assign bus.o_TX_Byte   = tx_byte_q;
    assign bus.o_Overrun   = overrun_q;
endmodule
